// File: rtl/frame_pkg.sv
// Frame geometry and capture FSM state type shared by the pixel serializer
// and the serial-to-parallel capture stage.
package frame_pkg;

   localparam int unsigned H_ACTIVE     = 640;
   localparam int unsigned V_ACTIVE     = 480;
   localparam int unsigned FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
   localparam int unsigned CNT_W        = 19;
   localparam int unsigned COLOR_W      = 10;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      STREAM,
      FLUSH
   } frame_state_e;

endpackage : frame_pkg

// File: rtl/luma_threshold.sv
// Two-stage pipeline: luminance sum (R + 2G + B), then compare of sum/4
// against the threshold. flush_i drops every pixel still in flight.
module luma_threshold #(
   parameter int unsigned COLOR_W = frame_pkg::COLOR_W
) (
   input  logic               iCLK,
   input  logic               iRST_n,
   input  logic               flush_i,
   input  logic               valid_i,
   input  logic [COLOR_W-1:0] r_i,
   input  logic [COLOR_W-1:0] g_i,
   input  logic [COLOR_W-1:0] b_i,
   input  logic [COLOR_W-1:0] thresh_i,
   output logic               s1_valid_o,
   output logic               valid_o,
   output logic               pixel_o
);

   localparam int unsigned SUM_W = COLOR_W + 2;

   logic [SUM_W-1:0] sum_d, sum_q;
   logic             s1_valid_q, s2_valid_q;
   logic             pixel_d, pixel_q;

   // Sum is wide enough for 4 * max channel value, so it never wraps.
   assign sum_d   = SUM_W'(r_i) + SUM_W'({g_i, 1'b0}) + SUM_W'(b_i);
   assign pixel_d = s1_valid_q && (sum_q[SUM_W-1:2] >= thresh_i);

   // Pipeline registers; a flush wins over any data moving this cycle.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         sum_q      <= '0;
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         pixel_q    <= 1'b0;
      end else if (flush_i) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         pixel_q    <= 1'b0;
      end else begin
         s1_valid_q <= valid_i;
         if (valid_i) begin
            sum_q <= sum_d;
         end
         s2_valid_q <= s1_valid_q;
         pixel_q    <= pixel_d;
      end
   end

   assign s1_valid_o = s1_valid_q;
   assign valid_o    = s2_valid_q;
   assign pixel_o    = pixel_q;

endmodule : luma_threshold

// File: rtl/pixel_binarize_serializer.sv
// Captures one camera frame on request, binarizes each pixel against a
// latched luminance threshold and emits it as a framed serial bit stream.
module pixel_binarize_serializer
   import frame_pkg::*;
#(
   parameter int unsigned H_ACTIVE = frame_pkg::H_ACTIVE,
   parameter int unsigned V_ACTIVE = frame_pkg::V_ACTIVE,
   parameter int unsigned COLOR_W  = frame_pkg::COLOR_W,
   parameter int unsigned CNT_W    = frame_pkg::CNT_W
) (
   input  logic               iCLK,
   input  logic               iRST_n,
   input  logic               iCAPTURE,
   input  logic [COLOR_W-1:0] iTHRESH,
   input  logic               iFRAME_START,
   input  logic               iDVAL,
   input  logic [COLOR_W-1:0] iR,
   input  logic [COLOR_W-1:0] iG,
   input  logic [COLOR_W-1:0] iB,
   output logic               oSTART,
   output logic               oVALID,
   output logic               oPIXEL,
   output logic               oDONE,
   output logic               oBUSY,
   output logic               oERROR
);

   localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(H_ACTIVE * V_ACTIVE);

   frame_state_e       state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [COLOR_W-1:0] thresh_q, thresh_d;
   logic               start_q, start_d;
   logic               done_q, done_d;
   logic               error_q, error_d;
   logic               busy_q;
   logic               accept_c;
   logic               flush_c;
   logic               s1_valid;

   // Next-state logic: capture handshake, pixel counting, short-frame restart.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      thresh_d = thresh_q;
      start_d  = 1'b0;
      done_d   = 1'b0;
      error_d  = 1'b0;
      accept_c = 1'b0;
      flush_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (iCAPTURE) begin
               thresh_d = iTHRESH;
               state_d  = ARM;
            end
         end
         ARM: begin
            // A pixel arriving with the frame start is not part of the frame.
            if (iFRAME_START) begin
               start_d = 1'b1;
               cnt_d   = '0;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (iFRAME_START) begin
               // Camera restarted early: drop partial frame and recapture.
               error_d = 1'b1;
               start_d = 1'b1;
               flush_c = 1'b1;
               cnt_d   = '0;
            end else if (iDVAL) begin
               accept_c = 1'b1;
               cnt_d    = cnt_q + CNT_W'(1);
               if (cnt_d == FRAME_CNT) begin
                  state_d = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (!s1_valid && !oVALID) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counter, threshold and registered control outputs.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         thresh_q <= '0;
         start_q  <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         thresh_q <= thresh_d;
         start_q  <= start_d;
         done_q   <= done_d;
         error_q  <= error_d;
         busy_q   <= (state_d != IDLE);
      end
   end

   luma_threshold #(
      .COLOR_W (COLOR_W)
   ) u_luma (
      .iCLK       (iCLK),
      .iRST_n     (iRST_n),
      .flush_i    (flush_c),
      .valid_i    (accept_c),
      .r_i        (iR),
      .g_i        (iG),
      .b_i        (iB),
      .thresh_i   (thresh_q),
      .s1_valid_o (s1_valid),
      .valid_o    (oVALID),
      .pixel_o    (oPIXEL)
   );

   assign oSTART = start_q;
   assign oDONE  = done_q;
   assign oERROR = error_q;
   assign oBUSY  = busy_q;

endmodule : pixel_binarize_serializer

// File: tb/tb_pixel_binarize_serializer.sv
// Self-checking bench for pixel_binarize_serializer on a reduced 4x2 frame.
module tb_pixel_binarize_serializer;

   localparam int unsigned CW   = 10;
   localparam int unsigned H    = 4;
   localparam int unsigned V    = 2;
   localparam int          NPIX = 8;

   logic          iCLK;
   logic          iRST_n;
   logic          iCAPTURE;
   logic [CW-1:0] iTHRESH;
   logic          iFRAME_START;
   logic          iDVAL;
   logic [CW-1:0] iR, iG, iB;
   logic          oSTART, oVALID, oPIXEL, oDONE, oBUSY, oERROR;

   pixel_binarize_serializer #(
      .H_ACTIVE (H),
      .V_ACTIVE (V),
      .COLOR_W  (CW),
      .CNT_W    (19)
   ) dut (
      .iCLK         (iCLK),
      .iRST_n       (iRST_n),
      .iCAPTURE     (iCAPTURE),
      .iTHRESH      (iTHRESH),
      .iFRAME_START (iFRAME_START),
      .iDVAL        (iDVAL),
      .iR           (iR),
      .iG           (iG),
      .iB           (iB),
      .oSTART       (oSTART),
      .oVALID       (oVALID),
      .oPIXEL       (oPIXEL),
      .oDONE        (oDONE),
      .oBUSY        (oBUSY),
      .oERROR       (oERROR)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   typedef struct {
      logic [CW-1:0] r;
      logic [CW-1:0] g;
      logic [CW-1:0] b;
      logic          exp;
   } vec_t;

   typedef struct {
      logic pix;
      int   cyc;
   } sb_t;

   vec_t tbl [NPIX];
   sb_t  sb [$];

   int cyc = 0;
   int tests = 0;
   int fails = 0;
   int fs_cyc = 0;
   int n_start = 0, n_done = 0, n_err = 0, n_valid = 0;
   int since_start = 0, last_start_cyc = -1, last_err_cyc = -1;
   logic prev_busy = 1'b0;

   always @(posedge iCLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Output monitor and scoreboard, sampled mid-cycle.
   always @(negedge iCLK) begin
      sb_t e;
      if (oVALID) begin
         n_valid++;
         since_start++;
         if (sb.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("pixel_value", 32'(oPIXEL), 32'(e.pix));
            check("pixel_latency", cyc, e.cyc);
         end
      end
      if (oSTART) begin
         n_start++;
         since_start = 0;
         last_start_cyc = cyc;
      end
      if (oERROR) begin
         n_err++;
         last_err_cyc = cyc;
         check("done_err_exclusive", 32'(oDONE), 32'd0);
      end
      if (oDONE) begin
         n_done++;
         check("valids_per_frame", since_start, NPIX);
         check("busy_low_at_done", 32'(oBUSY), 32'd0);
         check("busy_high_before_done", 32'(prev_busy), 32'd1);
      end
      prev_busy = oBUSY;
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge iCLK);
         #1;
      end
   endtask

   task automatic capture(input logic [CW-1:0] th);
      iCAPTURE = 1'b1;
      iTHRESH  = th;
      step();
      iCAPTURE = 1'b0;
   endtask

   task automatic frame_start();
      iFRAME_START = 1'b1;
      fs_cyc = cyc;
      step();
      iFRAME_START = 1'b0;
   endtask

   task automatic pixel(input int idx, input bit push);
      iDVAL = 1'b1;
      iR = tbl[idx].r;
      iG = tbl[idx].g;
      iB = tbl[idx].b;
      if (push) sb.push_back('{pix: tbl[idx].exp, cyc: cyc + 2});
      step();
      iDVAL = 1'b0;
   endtask

   task automatic run_frame(input int gap);
      for (int i = 0; i < NPIX; i++) begin
         pixel(i, 1'b1);
         if (gap > 0) step(gap);
      end
   endtask

   task automatic wait_done(input string name);
      int d0 = n_done;
      int k = 0;
      while (n_done == d0 && k < 100) begin
         step();
         k++;
      end
      check(name, n_done - d0, 32'd1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_start"}, 32'(oSTART), 32'd0);
      check({tag, "_valid"}, 32'(oVALID), 32'd0);
      check({tag, "_pixel"}, 32'(oPIXEL), 32'd0);
      check({tag, "_done"},  32'(oDONE),  32'd0);
      check({tag, "_busy"},  32'(oBUSY),  32'd0);
      check({tag, "_error"}, 32'(oERROR), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int s0, v0, e0, d0;

      // Expected bits for threshold 512: (R + 2G + B) / 4 >= 512.
      tbl[0] = '{r: 10'd600,  g: 10'd600,  b: 10'd600,  exp: 1'b1}; // 600
      tbl[1] = '{r: 10'd512,  g: 10'd512,  b: 10'd512,  exp: 1'b1}; // 512
      tbl[2] = '{r: 10'd511,  g: 10'd511,  b: 10'd511,  exp: 1'b0}; // 511
      tbl[3] = '{r: 10'd1023, g: 10'd0,    b: 10'd0,    exp: 1'b0}; // 255
      tbl[4] = '{r: 10'd0,    g: 10'd1023, b: 10'd0,    exp: 1'b0}; // 511
      tbl[5] = '{r: 10'd1023, g: 10'd1023, b: 10'd1023, exp: 1'b1}; // 1023
      tbl[6] = '{r: 10'd0,    g: 10'd0,    b: 10'd0,    exp: 1'b0}; // 0
      tbl[7] = '{r: 10'd0,    g: 10'd1023, b: 10'd2,    exp: 1'b1}; // 512

      iRST_n = 1'b0;
      iCAPTURE = 1'b0;
      iTHRESH = '0;
      iFRAME_START = 1'b0;
      iDVAL = 1'b0;
      iR = '0;
      iG = '0;
      iB = '0;
      step(3);
      check_outputs_zero("reset");
      iRST_n = 1'b1;
      step(2);

      // Continuous frame.
      s0 = n_start; v0 = n_valid; e0 = n_err;
      capture(10'd512);
      check("busy_after_capture", 32'(oBUSY), 32'd1);
      frame_start();
      run_frame(0);
      wait_done("t1_done");
      check("t1_starts", n_start - s0, 32'd1);
      check("t1_start_cycle", last_start_cyc, fs_cyc + 1);
      check("t1_valids", n_valid - v0, NPIX);
      check("t1_errors", n_err - e0, 32'd0);
      check("t1_sb_empty", sb.size(), 32'd0);
      step(3);

      // iDVAL one on, two off.
      s0 = n_start; v0 = n_valid;
      capture(10'd512);
      frame_start();
      run_frame(2);
      wait_done("t2_done");
      check("t2_starts", n_start - s0, 32'd1);
      check("t2_valids", n_valid - v0, NPIX);
      check("t2_sb_empty", sb.size(), 32'd0);
      step(3);

      // Short frame: restart after 5 pixels; the 5th is still in flight.
      s0 = n_start; v0 = n_valid; e0 = n_err;
      capture(10'd512);
      frame_start();
      for (int i = 0; i < 5; i++) pixel(i, i < 4);
      frame_start();
      run_frame(0);
      wait_done("t3_done");
      check("t3_errors", n_err - e0, 32'd1);
      check("t3_err_cycle", last_err_cyc, fs_cyc + 1);
      check("t3_starts", n_start - s0, 32'd2);
      check("t3_restart_cycle", last_start_cyc, fs_cyc + 1);
      check("t3_valids", n_valid - v0, 32'd12);
      check("t3_sb_empty", sb.size(), 32'd0);
      step(3);

      // Pixel alongside frame start is dropped; capture while busy is ignored.
      s0 = n_start; v0 = n_valid;
      capture(10'd512);
      iFRAME_START = 1'b1;
      iDVAL = 1'b1;
      iR = '0; iG = '0; iB = '0;
      fs_cyc = cyc;
      step();
      iFRAME_START = 1'b0;
      iDVAL = 1'b0;
      for (int i = 0; i < NPIX; i++) begin
         if (i == 0) begin
            iCAPTURE = 1'b1;
            iTHRESH = 10'd1000;
         end
         pixel(i, 1'b1);
         iCAPTURE = 1'b0;
      end
      wait_done("t4_done");
      check("t4_starts", n_start - s0, 32'd1);
      check("t4_valids", n_valid - v0, NPIX);
      check("t4_sb_empty", sb.size(), 32'd0);
      step(3);

      // No capture request: frame start and pixels produce nothing.
      s0 = n_start; v0 = n_valid;
      frame_start();
      for (int i = 0; i < 3; i++) pixel(i, 1'b0);
      step(5);
      check("idle_valids", n_valid - v0, 32'd0);
      check("idle_starts", n_start - s0, 32'd0);
      check("idle_busy", 32'(oBUSY), 32'd0);

      // Reset during pixel 3 aborts silently.
      d0 = n_done; e0 = n_err;
      capture(10'd512);
      frame_start();
      pixel(0, 1'b0);
      pixel(1, 1'b0);
      iDVAL = 1'b1;
      iR = tbl[2].r; iG = tbl[2].g; iB = tbl[2].b;
      iRST_n = 1'b0;
      step();
      iDVAL = 1'b0;
      check_outputs_zero("midreset");
      step(2);
      iRST_n = 1'b1;
      step(2);
      check("midreset_no_done", n_done - d0, 32'd0);
      check("midreset_no_error", n_err - e0, 32'd0);

      // Recovery frame after reset.
      s0 = n_start; v0 = n_valid;
      capture(10'd512);
      frame_start();
      run_frame(0);
      wait_done("t5_done");
      check("t5_starts", n_start - s0, 32'd1);
      check("t5_valids", n_valid - v0, NPIX);
      check("t5_sb_empty", sb.size(), 32'd0);
      step(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_pixel_binarize_serializer
